// File: rtl/derivative_seq_pkg.sv
// Shared types and default widths for the derivative sequencer.
package derivative_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_DECIM_W = 8;

endpackage

// File: rtl/derivative_seq_decim.sv
// Decimation down-counter: forwards one accepted sample, then drops the next decim.
module derivative_seq_decim
  import derivative_seq_pkg::*;
#(
  parameter int unsigned DECIM_W = DEF_DECIM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DECIM_W-1:0] decim,
  input  logic               accept,
  output logic               fwd
);

  logic [DECIM_W-1:0] decim_lat;
  logic [DECIM_W-1:0] dcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decim_lat <= '0;
      dcnt      <= '0;
    end else if (load) begin
      decim_lat <= decim;
      dcnt      <= '0;
    end else if (accept) begin
      if (dcnt == '0) dcnt <= decim_lat;
      else            dcnt <= dcnt - 1'b1;
    end
  end

  assign fwd = (dcnt == '0);

endmodule

// File: rtl/derivative_sequencer.sv
// Sequences an enb-gated Derivative datapath: handshaked input, decimation,
// priming discard and a backpressured result register.
module derivative_sequencer
  import derivative_seq_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned DECIM_W       = DEF_DECIM_W,
  parameter int unsigned PRIME_SAMPLES = 1,
  parameter int unsigned LATENCY       = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [DECIM_W-1:0] decim,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  output logic               s_ready,
  output logic               deriv_rst,
  output logic               deriv_enb,
  output logic [DATA_W-1:0]  deriv_in,
  input  logic [DATA_W-1:0]  deriv_u,
  output logic               m_valid,
  output logic [DATA_W-1:0]  m_data,
  input  logic               m_ready,
  output logic               busy
);

  state_t       state, state_next;
  logic         pend;
  logic [3:0]   prime_cnt;
  logic [LATENCY:0] cap_sr;
  logic         load, accept, fwd, fwd_go, cap;

  assign load   = (state == S_IDLE) && start;
  assign accept = s_valid && s_ready;
  assign fwd_go = accept && fwd;
  // Bit k is set k edges after the forwarding edge; top bit marks the capture edge.
  assign cap    = cap_sr[LATENCY];

  derivative_seq_decim #(
    .DECIM_W (DECIM_W)
  ) u_decim (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .decim  (decim),
    .accept (accept),
    .fwd    (fwd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (PRIME_SAMPLES == 0) ? S_RUN : S_PRIME;
      S_PRIME: begin
        if (stop)                            state_next = S_DRAIN;
        else if (cap && prime_cnt == 4'd1)   state_next = S_RUN;
      end
      S_RUN:   if (stop) state_next = S_DRAIN;
      S_DRAIN: if (!pend && (!m_valid || m_ready)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = ((state == S_PRIME) || (state == S_RUN)) && !pend && (!m_valid || m_ready);
    busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deriv_rst <= 1'b1;
      deriv_enb <= 1'b0;
      deriv_in  <= '0;
      pend      <= 1'b0;
      cap_sr    <= '0;
      prime_cnt <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
    end else begin
      deriv_rst <= (state_next == S_IDLE);
      deriv_enb <= fwd_go;
      cap_sr    <= {cap_sr[LATENCY-1:0], fwd_go};
      if (fwd_go) deriv_in <= s_data;

      if (fwd_go)   pend <= 1'b1;
      else if (cap) pend <= 1'b0;

      if (load)                          prime_cnt <= 4'(PRIME_SAMPLES);
      else if (cap && prime_cnt != 4'd0) prime_cnt <= prime_cnt - 4'd1;

      // A fresh capture outranks the handshake so a result is never lost.
      if (cap && prime_cnt == 4'd0) begin
        m_valid <= 1'b1;
        m_data  <= deriv_u;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_derivative_sequencer.sv
// Directed bench for derivative_sequencer with a behavioural Derivative datapath.
module tb_derivative_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, s_valid, m_ready;
  logic [7:0] decim, s_data;
  logic       s_ready, deriv_rst, deriv_enb, m_valid, busy;
  logic [7:0] deriv_in, deriv_u, m_data;

  int n_checks = 0;
  int n_fail   = 0;

  int         enb_cnt = 0, width_err = 0, gap_err = 0, cyc = 0, last_enb = -100;
  logic       prev_enb = 1'b0;
  logic [7:0] got[$];
  logic [7:0] prev_in = 8'd0;

  always #5 clk = ~clk;

  derivative_sequencer #(
    .DATA_W        (8),
    .DECIM_W       (8),
    .PRIME_SAMPLES (1),
    .LATENCY       (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .decim     (decim),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .deriv_rst (deriv_rst),
    .deriv_enb (deriv_enb),
    .deriv_in  (deriv_in),
    .deriv_u   (deriv_u),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy)
  );

  // Derivative datapath: u = In1 - previous In1, updated on enb.
  always @(posedge clk) begin
    if (deriv_rst) begin
      prev_in <= 8'd0;
      deriv_u <= 8'd0;
    end else if (deriv_enb) begin
      deriv_u <= deriv_in - prev_in;
      prev_in <= deriv_in;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (deriv_enb) begin
      enb_cnt++;
      if (prev_enb) width_err++;
      if (cyc - last_enb < 3) gap_err++;
      last_enb = cyc;
    end
    prev_enb = deriv_enb;
    if (m_valid && m_ready) got.push_back(m_data);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = v;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic wait_results(input int base, input int n);
    for (int i = 0; i < 300 && got.size() < base + n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_results(input string tag, input int base, input int n, input logic [7:0] exp);
    check({tag, "_count"}, got.size() - base, n);
    for (int k = 0; k < n; k++)
      check({tag, "_data"}, (base + k < got.size()) ? got[base + k] : 8'hxx, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rst"}, deriv_rst, 1);
    check({tag, "_sready"}, s_ready, 0);
  endtask

  task automatic ramp_run(input string tag);
    int b, e0;
    b = got.size(); e0 = enb_cnt;
    decim = 8'd0; m_ready = 1'b1;
    pulse_start();
    for (int v = 0; v < 5; v++) send(8'(v));
    wait_results(b, 4);
    check_results(tag, b, 4, 8'd1);
    check({tag, "_enb"}, enb_cnt - e0, 5);
    pulse_stop();
    wait_idle(tag);
  endtask

  initial begin
    int b, e0, e1;
    reset = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    s_data = 8'd0; decim = 8'd0; m_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_sready", s_ready, 0);
    check("rst_deriv_rst", deriv_rst, 1);
    check("rst_enb", deriv_enb, 0);
    check("rst_in", deriv_in, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    ramp_run("ramp");

    // Step by 2 with decim=1: forwarded 0,2,4,6,8.
    b = got.size(); e0 = enb_cnt;
    decim = 8'd1;
    pulse_start();
    for (int v = 0; v < 10; v++) send(8'(v));
    wait_results(b, 4);
    check_results("step2", b, 4, 8'd2);
    check("step2_enb", enb_cnt - e0, 5);
    check("step2_fwd_last", deriv_in, 8);
    pulse_stop();
    wait_idle("step2");

    // Backpressure on the first delivered result.
    b = got.size(); e0 = enb_cnt;
    decim = 8'd0; m_ready = 1'b0;
    pulse_start();
    fork
      for (int v = 0; v < 6; v++) send(8'(v));
      begin
        for (int i = 0; i < 300 && !m_valid; i++) @(negedge clk);
        check("bp_valid_seen", m_valid, 1);
        e1 = enb_cnt;
        repeat (10) begin
          check("bp_mvalid", m_valid, 1);
          check("bp_mdata", m_data, 1);
          check("bp_sready", s_ready, 0);
          @(negedge clk);
        end
        check("bp_enb_hold", enb_cnt - e1, 0);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_results(b, 5);
    check_results("bp", b, 5, 8'd1);
    check("bp_enb", enb_cnt - e0, 6);
    pulse_stop();
    wait_idle("bp");

    // Stop while a result is pending: it still gets delivered.
    b = got.size(); e0 = enb_cnt;
    decim = 8'd0; m_ready = 1'b1;
    pulse_start();
    send(8'd0);
    send(8'd1);
    pulse_stop();
    s_valid = 1'b1; s_data = 8'd9;
    @(negedge clk);
    check("drain_busy", busy, 1);
    check("drain_sready", s_ready, 0);
    wait_idle("drain");
    s_valid = 1'b0;
    check_results("drain", b, 1, 8'd1);
    check("drain_enb", enb_cnt - e0, 2);

    // Start in RUN is ignored (decim stays 1); start+stop in RUN drains.
    b = got.size(); e0 = enb_cnt;
    decim = 8'd1;
    pulse_start();
    send(8'd0);
    send(8'd1);
    decim = 8'd0;
    pulse_start();
    for (int v = 2; v < 6; v++) send(8'(v));
    wait_results(b, 2);
    check_results("ign_start", b, 2, 8'd2);
    check("ign_start_enb", enb_cnt - e0, 3);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("ss_busy", busy, 1);
    check("ss_sready", s_ready, 0);
    @(negedge clk);
    wait_idle("ss");

    // Async reset between enb and capture, then a clean repeat of the ramp.
    decim = 8'd0; m_ready = 1'b1;
    pulse_start();
    send(8'd0);
    send(8'd1);
    check("pre_rst_enb", deriv_enb, 1);
    #1 reset = 1'b1;
    #1;
    check("arst_enb", deriv_enb, 0);
    check("arst_deriv_rst", deriv_rst, 1);
    check("arst_mvalid", m_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in", deriv_in, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    ramp_run("rerun");

    check("enb_width_err", width_err, 0);
    check("enb_gap_err", gap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/derivative_sequencer.md
Name: derivative_sequencer

Overview:
- Sequences the enb-gated Derivative datapath (clk, reset, enb, In1 -> u).
- Accepts a sample stream over a valid/ready handshake and decimates it by a programmable ratio.
- Feeds exactly one enb pulse per forwarded sample, holds the datapath in reset between runs and discards the priming outputs after each start.
- Returns derivative results on a valid/ready output with backpressure. Sits between the sample source (ADC front end) and downstream filtering.

Parameters:
DATA_W, 8, width of samples, deriv_in, deriv_u and m_data
DECIM_W, 8, width of the decimation ratio input and its counter
PRIME_SAMPLES, 1, number of derivative results discarded after each start (0..15)
LATENCY, 1, clock edges from the datapath's enb edge until deriv_u is stable (1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset of the whole block
start  in  1  single-cycle pulse; begin a run (ignored unless IDLE)
stop  in  1  single-cycle pulse; end the run (ignored in IDLE/DRAIN)
decim  in  DECIM_W  forward 1 of every decim+1 accepted samples; sampled on start
s_valid  in  1  source sample valid
s_data  in  DATA_W  source sample
s_ready  out  1  sequencer accepts s_data this cycle
deriv_rst  out  1  drives Derivative reset, registered
deriv_enb  out  1  drives Derivative enb, registered, one-cycle pulse per forwarded sample
deriv_in  out  DATA_W  drives Derivative In1, registered, held between pulses
deriv_u  in  DATA_W  Derivative output u
m_valid  out  1  result valid
m_data  out  DATA_W  derivative result
m_ready  in  1  downstream accepts result
busy  out  1  high in PRIME, RUN, DRAIN

Behaviour:
- Reset values: s_ready=0, deriv_rst=1 (datapath held in reset during sequencer reset), deriv_enb=0, deriv_in=0, m_valid=0, m_data=0, busy=0, state=IDLE. deriv_rst stays 1 throughout IDLE.
- States are IDLE, PRIME, RUN and DRAIN.
- IDLE --start--> PRIME, or RUN if PRIME_SAMPLES=0. On that edge: latch decim, clear the decimation counter to 0, load prime_cnt=PRIME_SAMPLES, set deriv_rst=0.
- PRIME --prime_cnt reaches 0 on a discarded result--> RUN.
- PRIME or RUN --stop--> DRAIN.
- DRAIN --no pending result and m_valid=0 (or m_valid&&m_ready this cycle)--> IDLE, with deriv_rst=1.
- start and stop in the same cycle: in IDLE, start wins; in PRIME/RUN, stop wins.
- s_ready = (PRIME or RUN) && !pend && (!m_valid || m_ready). There is at most one outstanding datapath operation.
- Accept means s_valid&&s_ready at edge E0.
  - If dcnt==0, the sample is forwarded and dcnt<=decim_lat.
  - Otherwise the sample is consumed and dropped, and dcnt decrements.
  - With decim=0, every sample is forwarded.
- Forwarding at E0: deriv_in<=s_data, deriv_enb<=1 for exactly one cycle, pend<=1. The datapath updates at E1.
- Capture at edge E(1+LATENCY): pend<=0.
  - If prime_cnt>0, the result is discarded and prime_cnt decrements.
  - Otherwise m_data<=deriv_u and m_valid<=1.
- Minimum forwarded-sample spacing is LATENCY+2 cycles.
- m_valid/m_data are held stable until m_valid&&m_ready; then m_valid clears unless a new capture occurs the same edge. Capture has priority, so a result is never lost.
- Stop with pend=1: the pending result completes. It is discarded if still priming, otherwise delivered. No new samples are accepted in DRAIN.
- Arithmetic: only dcnt (DECIM_W, counts down) and prime_cnt (4 bits) are counted. Neither wraps; both saturate at 0. deriv_u passes through unmodified.
- Asynchronous reset mid-run returns every register to its reset value immediately. Any in-flight result is dropped.

Decomposition:
- Package derivative_seq_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_PRIME=2'd1, S_RUN=2'd2, S_DRAIN=2'd3
  - default widths DATA_W=8, DECIM_W=8
- One natural sub-module, derivative_seq_decim: the decimation down-counter with load (start), accept strobe and forward output.
- FSM, pend/latency shift register and output register stay in the top level.

Test Plan:
- Ramp, decim=0, PRIME=1, LATENCY=1: start, stream 0,1,2,3,4 with m_ready=1 -> first result discarded; m_data=1,1,1,1; exactly 5 deriv_enb pulses, each 1 cycle, spaced ≥3 cycles.
- Step by 2, decim=1: stream 0..9 -> forwarded 0,2,4,6,8; deriv_enb count=5; after prime, m_data=2,2,2,2.
- Backpressure: ramp with m_ready=0 for 10 cycles after first m_valid -> m_valid and m_data=1 held; s_ready=0; no deriv_enb pulses; on release the stream resumes with no result lost or duplicated.
- Stop with pend=1 in RUN -> pending result delivered; s_ready=0 in DRAIN; IDLE after handshake; deriv_rst=1, busy=0.
- start and stop in the same cycle while RUN -> enters DRAIN. Start pulse in RUN -> ignored; decim unchanged.
- Async reset asserted between enb and capture -> outputs immediately at reset values (deriv_rst=1, m_valid=0). A restart with ramp reproduces scenario 1 exactly.
